// File: rtl/uart_sim_pkg.sv
// Shared definitions for the simulated UART character path.
// Used by the UART-in responder and by the bench-side UART-out monitor.
package uart_sim_pkg;

  // Value the DUT sees when no character is available.
  localparam logic [7:0] UART_NO_CHAR  = 8'hff;

  // Bit position used by the UART-out side to flag a trap character.
  localparam int         UART_TRAP_BIT = 7;

  typedef logic [7:0] uart_ch_t;

  // Width of an occupancy value able to represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_sim_pkg

// File: rtl/sim_char_fifo.sv
// Character FIFO with a combinationally visible head entry.
// Pointers carry one extra wrap bit, so full and empty are never ambiguous.
module sim_char_fifo
  import uart_sim_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  uart_ch_t                 push_ch,
  input  logic                     pop,
  output uart_ch_t                 head_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  uart_ch_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Occupancy is the distance between the extended pointers.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_ch = mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a character written here is readable only after the edge.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately left unreset; pointer reset alone makes old contents unreachable.
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_ch;
  end

endmodule : sim_char_fifo

// File: rtl/uart_in_responder.sv
// Answers DUT UART-in read requests from a host-filled character FIFO,
// enforcing a minimum idle gap between delivered characters and keeping
// delivery / empty-read statistics.
module uart_in_responder
  import uart_sim_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [7:0]               host_ch,
  input  logic                     io_uart_in_valid,
  output logic [7:0]               io_uart_in_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              delivered_cnt,
  output logic [31:0]              empty_reads
);

  uart_ch_t     head_ch;
  logic         fifo_full;
  logic         fifo_empty;
  logic [15:0]  gap_cnt;
  logic         deliverable;
  logic         do_push;
  logic         do_pop;
  logic         do_empty_read;

  // Request/response decode; reset masks everything so that cycle is ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    deliverable   = 1'b0;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    do_empty_read = 1'b0;
    host_ready    = 1'b0;
    io_uart_in_ch = UART_NO_CHAR;
    if (!reset) begin
      deliverable   = !fifo_empty && (gap_cnt == '0);
      host_ready    = !fifo_full;
      do_push       = host_valid && !fifo_full;
      do_pop        = io_uart_in_valid && deliverable;
      do_empty_read = io_uart_in_valid && !deliverable;
      if (deliverable) io_uart_in_ch = head_ch;
    end
  end

  sim_char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (do_push),
    .push_ch (host_ch),
    .pop     (do_pop),
    .head_ch (head_ch),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Inter-character gap: a delivery reloads GAP, otherwise count down to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (do_pop) begin
      gap_cnt <= 16'(GAP);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 16'd1;
    end
  end

  // Statistics; both counters wrap modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      delivered_cnt <= '0;
      empty_reads   <= '0;
    end else begin
      if (do_pop)        delivered_cnt <= delivered_cnt + 32'd1;
      if (do_empty_read) empty_reads   <= empty_reads + 32'd1;
    end
  end

endmodule : uart_in_responder
